// File: rtl/q_enc_pkg.sv
// Shared constants and helpers for the quadrature encoder block:
// scale-mode encodings, register map, counter width and step decoding.
package q_enc_pkg;

    typedef enum logic [1:0] {
        SCALE_X4     = 2'd0,
        SCALE_X2     = 2'd1,
        SCALE_X1     = 2'd2,
        SCALE_X1_ALT = 2'd3
    } scale_mode_e;

    localparam logic [7:0] REG_ZMASK_ADDR = 8'd1;
    localparam int         CNT_W          = 32;
    localparam int         RES_W          = 4;

    function automatic logic signed [RES_W-1:0] scale_div(input logic [1:0] mode);
        case (scale_mode_e'(mode))
            SCALE_X4: return 4'sd4;
            SCALE_X2: return 4'sd2;
            default:  return 4'sd1;
        endcase
    endfunction

    // Position along 00->10->11->01; the modular difference is the step
    // (1 = forward, 3 = reverse, 0 = none, 2 = both lines moved).
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    function automatic logic [1:0] quad_delta(input logic [1:0] old_ab,
                                              input logic [1:0] new_ab);
        return quad_pos(new_ab) - quad_pos(old_ab);
    endfunction

endpackage

// File: rtl/q_enc_ram.sv
// Counter RAM: engine port with combinational read and write priority,
// host port with one-cycle registered read.
module q_enc_ram
    import q_enc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             eng_we,
    input  logic [4:0]       eng_addr,
    input  logic [CNT_W-1:0] eng_wd,
    output logic [CNT_W-1:0] eng_rd,
    input  logic             host_en,
    input  logic             host_we,
    input  logic [4:0]       host_addr,
    input  logic [CNT_W-1:0] host_wd,
    output logic [CNT_W-1:0] host_rd
);

    localparam int AW = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] host_rd_q;
    logic [AW-1:0]    eng_idx;
    logic [AW-1:0]    host_idx;

    assign eng_idx  = eng_addr[AW-1:0];
    assign host_idx = host_addr[AW-1:0];
    assign eng_rd   = mem_q[eng_idx];
    assign host_rd  = host_rd_q;

    // Engine write is issued last so it overrides a same-address host write
    always_ff @(posedge clk) begin
        if (host_en && host_we && (int'(host_addr) < DEPTH)) begin
            mem_q[host_idx] <= host_wd;
        end
        if (eng_we && (int'(eng_addr) < DEPTH)) begin
            mem_q[eng_idx] <= eng_wd;
        end
        if (host_en) begin
            host_rd_q <= mem_q[host_idx];
        end
    end

endmodule

// File: rtl/q_enc.sv
// Multi-channel quadrature encoder: scanned per-channel step decoding with
// prescaling into a shared counter RAM, error flags and Z-index detection.
module q_enc
    import q_enc_pkg::*;
#(
    parameter int          NUM_ENCS = 8,
    parameter logic [63:0] SETUP    = 64'h0202020202020202
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ENCS-1:0] a_inp,
    input  logic [NUM_ENCS-1:0] b_inp,
    input  logic [NUM_ENCS-1:0] z_inp,
    input  logic                reg_cs,
    input  logic [7:0]          reg_addr,
    input  logic [31:0]         reg_data,
    output logic                z_hit,
    output logic                fatal_ovl,
    output logic                fatal_inv_trans,
    output logic [4:0]          fatal_idx,
    output logic [4:0]          wr_addr,
    output logic                wr_hit,
    input  logic                ram_en,
    input  logic                ram_we,
    input  logic [4:0]          ram_addr,
    input  logic [CNT_W-1:0]    ram_di,
    output logic [CNT_W-1:0]    ram_do,
    input  logic                qenc_enable
);

    localparam logic signed [RES_W-1:0] STEP_P = 4'sd1;
    localparam logic signed [RES_W-1:0] STEP_N = -4'sd1;

    logic [NUM_ENCS-1:0] a_s1_q, a_s2_q, a_s3_q;
    logic [NUM_ENCS-1:0] b_s1_q, b_s2_q, b_s3_q;
    logic [NUM_ENCS-1:0] z_s1_q, z_s2_q, z_s3_q;
    logic [4:0]          ptr_q, ptr_d;
    logic [1:0]          last_q [NUM_ENCS];
    logic [1:0]          last_d [NUM_ENCS];
    logic signed [RES_W-1:0] res_q [NUM_ENCS];
    logic signed [RES_W-1:0] res_d [NUM_ENCS];
    logic [NUM_ENCS-1:0] valid_q, valid_d, chg_q, chg_d, mask_q, mask_d;
    logic                z_hit_q, z_hit_d;
    logic                fatal_ovl_q, fatal_ovl_d, fatal_inv_q, fatal_inv_d;
    logic [4:0]          fatal_idx_q, fatal_idx_d;
    logic                wr_hit_q, wr_hit_d;
    logic [4:0]          wr_addr_q, wr_addr_d;
    logic                eng_we;
    logic [CNT_W-1:0]    eng_rd, eng_wd;
    logic                ovl_err, inv_err;
    logic [4:0]          ovl_ch, inv_ch;
    logic                fatal_any;
    logic                reg_data_unused;

    assign fatal_any       = fatal_ovl_q | fatal_inv_q;
    assign reg_data_unused = ^reg_data;

    q_enc_ram #(.DEPTH(NUM_ENCS)) u_ram (
        .clk       (clk),
        .eng_we    (eng_we),
        .eng_addr  (ptr_q),
        .eng_wd    (eng_wd),
        .eng_rd    (eng_rd),
        .host_en   (ram_en),
        .host_we   (ram_we),
        .host_addr (ram_addr),
        .host_wd   (ram_di),
        .host_rd   (ram_do)
    );

    always_comb begin : svc_comb
        logic [1:0]              cur_ab;
        logic [1:0]              delta;
        logic                    chg_ev;
        logic signed [RES_W-1:0] sum;
        logic signed [RES_W-1:0] div;
        cur_ab  = '0;
        delta   = '0;
        chg_ev  = 1'b0;
        sum     = '0;
        div     = '0;
        last_d  = last_q;
        res_d   = res_q;
        valid_d = valid_q;
        chg_d   = chg_q;
        eng_we  = 1'b0;
        eng_wd  = eng_rd;
        ovl_err = 1'b0;
        ovl_ch  = '0;
        inv_err = 1'b0;
        inv_ch  = '0;
        for (int i = 0; i < NUM_ENCS; i++) begin
            cur_ab = {a_s2_q[i], b_s2_q[i]};
            chg_ev = (cur_ab != {a_s3_q[i], b_s3_q[i]});
            if (!qenc_enable) begin
                valid_d[i] = 1'b0;
                chg_d[i]   = 1'b0;
            end else begin
                if (chg_ev && chg_q[i] && valid_q[i] && !ovl_err) begin
                    ovl_err = 1'b1;
                    ovl_ch  = 5'(i);
                end
                chg_d[i] = (ptr_q == 5'(i)) ? 1'b0 : (chg_q[i] | chg_ev);
                if (ptr_q == 5'(i)) begin
                    last_d[i]  = cur_ab;
                    valid_d[i] = 1'b1;
                    if (!valid_q[i]) begin
                        res_d[i] = '0;
                    end else begin
                        delta = quad_delta(last_q[i], cur_ab);
                        // Channels past the 8 SETUP bytes reuse byte (i mod 8)
                        div   = scale_div(SETUP[8*(i%8) +: 2]);
                        if (delta == 2'd2) begin
                            inv_err = 1'b1;
                            inv_ch  = 5'(i);
                        end else if (!fatal_any && delta != 2'd0) begin
                            sum = res_q[i] + ((delta == 2'd1) ? STEP_P : STEP_N);
                            if (sum == div) begin
                                eng_we   = 1'b1;
                                eng_wd   = eng_rd + 32'd1;
                                res_d[i] = '0;
                            end else if (sum == -div) begin
                                eng_we   = 1'b1;
                                eng_wd   = eng_rd - 32'd1;
                                res_d[i] = '0;
                            end else begin
                                res_d[i] = sum;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_d       = (ptr_q == 5'(NUM_ENCS - 1)) ? 5'd0 : ptr_q + 5'd1;
        mask_d      = mask_q;
        z_hit_d     = z_hit_q | (|(z_s2_q & ~z_s3_q & mask_q));
        if (reg_cs && reg_addr == REG_ZMASK_ADDR) begin
            mask_d  = reg_data[NUM_ENCS-1:0];
            z_hit_d = 1'b0;
        end
        fatal_ovl_d = 1'b0;
        fatal_inv_d = 1'b0;
        fatal_idx_d = fatal_idx_q;
        if (qenc_enable) begin
            fatal_ovl_d = fatal_ovl_q | ovl_err;
            fatal_inv_d = fatal_inv_q | inv_err;
            if (!fatal_any && (inv_err || ovl_err)) begin
                fatal_idx_d = inv_err ? inv_ch : ovl_ch;
            end
        end
        wr_hit_d    = eng_we;
        wr_addr_d   = eng_we ? ptr_q : wr_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            a_s3_q      <= '0;
            b_s1_q      <= '0;
            b_s2_q      <= '0;
            b_s3_q      <= '0;
            z_s1_q      <= '0;
            z_s2_q      <= '0;
            z_s3_q      <= '0;
            ptr_q       <= '0;
            valid_q     <= '0;
            chg_q       <= '0;
            mask_q      <= '0;
            z_hit_q     <= 1'b0;
            fatal_ovl_q <= 1'b0;
            fatal_inv_q <= 1'b0;
            fatal_idx_q <= '0;
            wr_hit_q    <= 1'b0;
            wr_addr_q   <= '0;
            for (int i = 0; i < NUM_ENCS; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            a_s1_q      <= a_inp;
            a_s2_q      <= a_s1_q;
            a_s3_q      <= a_s2_q;
            b_s1_q      <= b_inp;
            b_s2_q      <= b_s1_q;
            b_s3_q      <= b_s2_q;
            z_s1_q      <= z_inp;
            z_s2_q      <= z_s1_q;
            z_s3_q      <= z_s2_q;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            chg_q       <= chg_d;
            mask_q      <= mask_d;
            z_hit_q     <= z_hit_d;
            fatal_ovl_q <= fatal_ovl_d;
            fatal_inv_q <= fatal_inv_d;
            fatal_idx_q <= fatal_idx_d;
            wr_hit_q    <= wr_hit_d;
            wr_addr_q   <= wr_addr_d;
            res_q       <= res_d;
        end
    end

    // Last {A,B} is meaningless until the valid bit is set, so it is never reset
    always_ff @(posedge clk) begin
        last_q <= last_d;
    end

    assign z_hit           = z_hit_q;
    assign fatal_ovl       = fatal_ovl_q;
    assign fatal_inv_trans = fatal_inv_q;
    assign fatal_idx       = fatal_idx_q;
    assign wr_hit          = wr_hit_q;
    assign wr_addr         = wr_addr_q;

endmodule

// File: tb/tb_q_enc.sv
// Directed bench for q_enc: channel 6 runs scale mode 0, channel 7 mode 1,
// all other channels mode 2.
module tb_q_enc;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a_inp, b_inp, z_inp;
    logic        reg_cs;
    logic [7:0]  reg_addr;
    logic [31:0] reg_data;
    logic        z_hit, fatal_ovl, fatal_inv_trans, wr_hit;
    logic [4:0]  fatal_idx, wr_addr;
    logic        ram_en, ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_di, ram_do;
    logic        qenc_enable;

    int checks   = 0;
    int failures = 0;
    int hit_cnt [32] = '{default: 0};
    int snap    [32];

    q_enc #(.NUM_ENCS(8), .SETUP(64'h0100_0202_0202_0202)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_inp           (a_inp),
        .b_inp           (b_inp),
        .z_inp           (z_inp),
        .reg_cs          (reg_cs),
        .reg_addr        (reg_addr),
        .reg_data        (reg_data),
        .z_hit           (z_hit),
        .fatal_ovl       (fatal_ovl),
        .fatal_inv_trans (fatal_inv_trans),
        .fatal_idx       (fatal_idx),
        .wr_addr         (wr_addr),
        .wr_hit          (wr_hit),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_di          (ram_di),
        .ram_do          (ram_do),
        .qenc_enable     (qenc_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_hit === 1'b1) hit_cnt[wr_addr] <= hit_cnt[wr_addr] + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [4:0] a, input logic [31:0] d);
        ram_en = 1'b1; ram_we = 1'b1; ram_addr = a; ram_di = d;
        wait_clks(1);
        ram_en = 1'b0; ram_we = 1'b0;
    endtask

    task automatic ram_read(input logic [4:0] a, output logic [31:0] v);
        ram_en = 1'b1; ram_we = 1'b0; ram_addr = a;
        wait_clks(1);
        v = ram_do;
        ram_en = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        reg_cs = 1'b1; reg_addr = a; reg_data = d;
        wait_clks(1);
        reg_cs = 1'b0;
    endtask

    // One quadrature step per call iteration, held long enough for a full scan
    task automatic step_ch(input int ch, input bit fwd, input int n);
        logic [1:0] ab, nx;
        for (int k = 0; k < n; k++) begin
            ab = {a_inp[ch], b_inp[ch]};
            case (ab)
                2'b00:   nx = fwd ? 2'b10 : 2'b01;
                2'b10:   nx = fwd ? 2'b11 : 2'b00;
                2'b11:   nx = fwd ? 2'b01 : 2'b10;
                default: nx = fwd ? 2'b00 : 2'b11;
            endcase
            a_inp[ch] = nx[1];
            b_inp[ch] = nx[0];
            wait_clks(12);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        checks++; if (z_hit !== 1'b0) begin failures++; $display("FAIL reset_z_hit got=%b exp=0", z_hit); end
        checks++; if (fatal_ovl !== 1'b0) begin failures++; $display("FAIL reset_ovl got=%b exp=0", fatal_ovl); end
        checks++; if (fatal_inv_trans !== 1'b0) begin failures++; $display("FAIL reset_inv got=%b exp=0", fatal_inv_trans); end
        checks++; if (fatal_idx !== 5'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", fatal_idx); end
        checks++; if (wr_hit !== 1'b0 || wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr got=%b/%0d exp=0/0", wr_hit, wr_addr); end
        rst_n = 1'b1;
        wait_clks(1);
        for (int i = 0; i < 8; i++) ram_write(5'(i), 32'd0);
    endtask

    task automatic test_disabled();
        logic [31:0] v;
        int tot;
        qenc_enable = 1'b0;
        snap = hit_cnt;
        step_ch(0, 1'b1, 10);
        wait_clks(14);
        ram_read(5'd0, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL dis_ram0 got=%0d exp=0", $signed(v)); end
        tot = 0;
        for (int i = 0; i < 32; i++) tot += hit_cnt[i] - snap[i];
        checks++; if (tot !== 0) begin failures++; $display("FAIL dis_wr_hit got=%0d exp=0", tot); end
    endtask

    task automatic test_mode2();
        logic [31:0] v;
        int tot;
        qenc_enable = 1'b1;
        wait_clks(12);
        snap = hit_cnt;
        step_ch(3, 1'b1, 7);
        step_ch(5, 1'b0, 4);
        wait_clks(14);
        ram_read(5'd3, v);
        checks++; if (v !== 32'd7) begin failures++; $display("FAIL m2_ram3 got=%0d exp=7", $signed(v)); end
        ram_read(5'd5, v);
        checks++; if (v !== 32'hFFFF_FFFC) begin failures++; $display("FAIL m2_ram5 got=%0d exp=-4", $signed(v)); end
        checks++; if (hit_cnt[3] - snap[3] !== 7) begin failures++; $display("FAIL m2_hits3 got=%0d exp=7", hit_cnt[3] - snap[3]); end
        checks++; if (hit_cnt[5] - snap[5] !== 4) begin failures++; $display("FAIL m2_hits5 got=%0d exp=4", hit_cnt[5] - snap[5]); end
        tot = 0;
        for (int i = 0; i < 32; i++) tot += hit_cnt[i] - snap[i];
        checks++; if (tot !== 11) begin failures++; $display("FAIL m2_hits_total got=%0d exp=11", tot); end
    endtask

    task automatic test_scale();
        logic [31:0] v;
        snap = hit_cnt;
        step_ch(6, 1'b1, 9);
        step_ch(7, 1'b0, 5);
        wait_clks(14);
        ram_read(5'd6, v);
        checks++; if (v !== 32'd2) begin failures++; $display("FAIL mode0_ram6 got=%0d exp=2", $signed(v)); end
        ram_read(5'd7, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mode1_ram7 got=%0d exp=-2", $signed(v)); end
        checks++; if (hit_cnt[6] - snap[6] !== 2) begin failures++; $display("FAIL mode0_hits got=%0d exp=2", hit_cnt[6] - snap[6]); end
        checks++; if (hit_cnt[7] - snap[7] !== 2) begin failures++; $display("FAIL mode1_hits got=%0d exp=2", hit_cnt[7] - snap[7]); end
    endtask

    task automatic test_inv();
        logic [31:0] v;
        a_inp[0] = ~a_inp[0];
        b_inp[0] = ~b_inp[0];
        wait_clks(12);
        checks++; if (fatal_inv_trans !== 1'b1) begin failures++; $display("FAIL inv_flag got=%b exp=1", fatal_inv_trans); end
        checks++; if (fatal_idx !== 5'd0) begin failures++; $display("FAIL inv_idx got=%0d exp=0", fatal_idx); end
        checks++; if (fatal_ovl !== 1'b0) begin failures++; $display("FAIL inv_no_ovl got=%b exp=0", fatal_ovl); end
        step_ch(3, 1'b1, 1);
        wait_clks(14);
        ram_read(5'd3, v);
        checks++; if (v !== 32'd7) begin failures++; $display("FAIL inv_frozen_ram3 got=%0d exp=7", $signed(v)); end
        qenc_enable = 1'b0;
        wait_clks(10);
        qenc_enable = 1'b1;
        wait_clks(2);
        checks++; if (fatal_inv_trans !== 1'b0) begin failures++; $display("FAIL inv_clear got=%b exp=0", fatal_inv_trans); end
        checks++; if (fatal_ovl !== 1'b0) begin failures++; $display("FAIL inv_clear_ovl got=%b exp=0", fatal_ovl); end
    endtask

    task automatic test_ovl();
        wait_clks(12);
        for (int k = 0; k < 24; k++) begin
            a_inp[4:0] = ~a_inp[4:0];
            wait_clks(1);
        end
        wait_clks(4);
        checks++; if (fatal_ovl !== 1'b1) begin failures++; $display("FAIL ovl_flag got=%b exp=1", fatal_ovl); end
        checks++; if (fatal_inv_trans !== 1'b0) begin failures++; $display("FAIL ovl_no_inv got=%b exp=0", fatal_inv_trans); end
        checks++; if (fatal_idx > 5'd4) begin failures++; $display("FAIL ovl_idx got=%0d exp=0..4", fatal_idx); end
        qenc_enable = 1'b0;
        wait_clks(10);
        qenc_enable = 1'b1;
        wait_clks(2);
        checks++; if (fatal_ovl !== 1'b0) begin failures++; $display("FAIL ovl_clear got=%b exp=0", fatal_ovl); end
        checks++; if (fatal_inv_trans !== 1'b0) begin failures++; $display("FAIL ovl_clear_inv got=%b exp=0", fatal_inv_trans); end
    endtask

    task automatic test_zhit();
        reg_write(8'd1, 32'hFFFF_FFFF);
        wait_clks(4);
        checks++; if (z_hit !== 1'b0) begin failures++; $display("FAIL z_idle got=%b exp=0", z_hit); end
        z_inp[0] = 1'b1;
        wait_clks(2);
        z_inp[0] = 1'b0;
        wait_clks(3);
        checks++; if (z_hit !== 1'b1) begin failures++; $display("FAIL z_pulse got=%b exp=1", z_hit); end
        reg_write(8'd2, 32'd0);
        checks++; if (z_hit !== 1'b1) begin failures++; $display("FAIL z_other_addr got=%b exp=1", z_hit); end
        reg_write(8'd1, 32'd0);
        checks++; if (z_hit !== 1'b0) begin failures++; $display("FAIL z_clear got=%b exp=0", z_hit); end
        reg_write(8'd1, 32'h0000_0002);
        z_inp[0] = 1'b1;
        wait_clks(2);
        z_inp[0] = 1'b0;
        wait_clks(3);
        checks++; if (z_hit !== 1'b0) begin failures++; $display("FAIL z_masked got=%b exp=0", z_hit); end
        z_inp[1] = 1'b1;
        wait_clks(2);
        z_inp[1] = 1'b0;
        wait_clks(3);
        checks++; if (z_hit !== 1'b1) begin failures++; $display("FAIL z_armed_ch1 got=%b exp=1", z_hit); end
    endtask

    task automatic test_host();
        logic [31:0] v;
        ram_write(5'd1, 32'hDEAD_BEEF);
        ram_read(5'd1, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL host_rd got=%h exp=deadbeef", v); end
    endtask

    initial begin
        rst_n = 1'b0; a_inp = '0; b_inp = '0; z_inp = '0;
        reg_cs = 1'b0; reg_addr = '0; reg_data = '0;
        ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_di = '0;
        qenc_enable = 1'b0;
        #1;
        test_reset();
        test_disabled();
        test_mode2();
        test_scale();
        test_inv();
        test_ovl();
        test_zhit();
        test_host();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q_enc.md
Q_ENC -- requirements
Module: q_enc

Interface
REQ-001 SHALL have parameter NUM_ENCS, default 8: number of encoder channels, 1..32.
REQ-002 SHALL have parameter SETUP, 64-bit, default 64'h0202020202020202: byte i configures channel i; bits[1:0] give the scale mode, bits[7:2] are reserved.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports a_inp / b_inp / z_inp, input, NUM_ENCS bits each: asynchronous quadrature A, B and index Z, one bit per channel.
REQ-006 SHALL have ports reg_cs (1), reg_addr (8) and reg_data (32), inputs: register write strobe, address and data.
REQ-007 SHALL have port z_hit, output, 1 bit: Z index seen on an armed channel.
REQ-008 SHALL have ports fatal_ovl and fatal_inv_trans, outputs, 1 bit each: sticky error flags.
REQ-009 SHALL have port fatal_idx, output, 5 bits: channel of the first fatal error.
REQ-010 SHALL have ports wr_addr (5 bits) and wr_hit (1 bit), outputs: counter-update notification.
REQ-011 SHALL have ports ram_en (1), ram_we (1), ram_addr (5) and ram_di (32), inputs, and ram_do (32), output: host port to the counter RAM.
REQ-012 SHALL have port qenc_enable, input, 1 bit: global enable.

Function
REQ-013 SHALL pass A, B and Z of every channel through 2-flop synchronizers.
REQ-014 SHALL service one channel per clk with a scan pointer 0..NUM_ENCS-1 that wraps to 0.
REQ-015 SHALL compare, on service, the synced {A,B} with the stored last {A,B} and then store the new value.
REQ-016 SHALL make sequence 00->10->11->01->00 one step +1; the reverse order is -1; no change is 0.
REQ-017 SHALL, when both A and B differ from the stored value, set fatal_inv_trans and apply no count.
REQ-018 SHALL set fatal_ovl when the synced {A,B} of a channel changes more than once between two services of that channel (per-channel change flag, cleared on service).
REQ-019 SHALL, on the first fatal error, latch fatal_idx to the offending channel; later errors leave fatal_idx unchanged.
REQ-020 SHALL hold both fatal flags while qenc_enable=1 and clear them when qenc_enable=0.
REQ-021 SHALL freeze all counting while either fatal flag is set.
REQ-022 SHALL keep a per-channel signed residue and divisor d; d=1 for mode 2 or 3, d=2 for mode 1, d=4 for mode 0.
REQ-023 SHALL add each step to the residue; when the residue reaches +d or -d, the RAM word changes by ±1 and the residue returns to 0.
REQ-024 SHALL hold counters as a 32-bit two's-complement RAM with NUM_ENCS words, wrapping on overflow.
REQ-025 SHALL complete each update as a read-modify-write within the service cycle and pulse wr_hit for 1 clk, with wr_addr=channel, one clk after the write.
REQ-026 SHALL give the host port read latency 1 clk (ram_do).
REQ-027 SHALL, on a same-cycle host write and engine write to one address, let the engine write win.
REQ-028 SHALL define register address 1 as Z arm mask: a write loads mask=reg_data[NUM_ENCS-1:0] and clears z_hit; writes to other addresses are ignored.
REQ-029 SHALL set z_hit on a synced Z rising edge of a channel whose mask bit is 1, and hold it until the next write to address 1.
REQ-030 SHALL, while qenc_enable=0, perform no counting and no wr_hit, and mark every channel's last-{A,B} invalid.
REQ-031 SHALL make the first service of an invalid channel only load last-{A,B} (no count, no error) and clear that channel's residue.

Reset
REQ-032 SHALL make rst_n=0 clear the synchronizers, scan pointer, valid bits, residues, change flags, mask, z_hit, fatal_ovl, fatal_inv_trans, fatal_idx (0), wr_hit and wr_addr (0).
REQ-033 SHALL leave RAM contents unaffected by rst_n.

Structure
REQ-034 SHALL place scale-mode encodings, the register address constant (1) and the counter width (32) in shared package q_enc_pkg.
REQ-035 SHALL implement the counter RAM as sub-module q_enc_ram: one clock, two ports, 32 x NUM_ENCS words.

Verification
REQ-036 SHALL cover: qenc_enable=0 with 10 forward steps on ch0 -> RAM[0] stays 0 and no wr_hit.
REQ-037 SHALL cover: enabled, mode 2, ch3 with 7 forward steps and ch5 with 4 reverse steps -> RAM[3]=7, RAM[5]=-4, wr_hit seen only for addresses 3 and 5.
REQ-038 SHALL cover: mode 0 with 9 forward steps -> RAM=2; mode 1 with 5 reverse steps -> RAM=-2.
REQ-039 SHALL cover: ch0 A and B toggled in the same cycle -> fatal_inv_trans=1 and fatal_idx=0; qenc_enable low for 10 clk then high -> both flags 0.
REQ-040 SHALL cover: channels 0..4 toggling every clk -> fatal_ovl=1; enable cycled -> flags cleared.
REQ-041 SHALL cover: write addr1=32'hFFFFFFFF, no Z -> z_hit=0; Z pulse on ch0 -> z_hit=1; write addr1=0 -> z_hit=0 the next clk.
